// File: rtl/i2c_lcd_byte_sender.sv
// i2c_lcd_byte_sender
// Sends one LCD byte (command or character) to an HD44780 behind a PCF8574
// I2C backpack. The byte is split into four port writes that toggle EN around
// each nibble (4-bit LCD mode), each handed to an external I2C byte master.
//
// Ports:
//   clk_1MHz     in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   ena_write    in   one-cycle request (accepted only when idle)
//   data[7:0]    in   byte to send
//   cmd_data     in   0 = command (RS=0), 1 = character (RS=1)
//   backlight    in   backlight bit for all four port writes
//   done_write   out  one-cycle pulse: transfer finished or aborted
//   busy         out  high from acceptance through the done_write cycle
//   err          out  one-cycle pulse with done_write on NACK abort
//   i2c_start    out  one-cycle request to the I2C byte master
//   i2c_addr     out  7-bit slave address (SLAVE_ADDR)
//   i2c_data     out  PCF8574 port byte, held from i2c_start to i2c_done
//   i2c_done     in   master finished the current byte
//   i2c_ack_err  in   valid with i2c_done; 1 = slave NACK
module i2c_lcd_byte_sender #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h27,
    parameter int unsigned GAP_CYCLES = 50
) (
    input  logic       clk_1MHz,
    input  logic       rst,
    input  logic       ena_write,
    input  logic [7:0] data,
    input  logic       cmd_data,
    input  logic       backlight,
    output logic       done_write,
    output logic       busy,
    output logic       err,
    output logic       i2c_start,
    output logic [6:0] i2c_addr,
    output logic [7:0] i2c_data,
    input  logic       i2c_done,
    input  logic       i2c_ack_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam int unsigned   GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);

    logic [2:0]    state;
    logic [1:0]    step;
    logic [GW-1:0] gap_cnt;
    logic          err_flag;
    logic [7:0]    data_q;
    logic          rs_q;
    logic          bl_q;

    // PCF8574 wiring: bit0=RS, bit1=RW(0), bit2=EN, bit3=BL, bits7:4=nibble.
    // Steps 0/1 carry the high nibble, 2/3 the low; EN is high on even steps.
    function automatic logic [7:0] port_byte(input logic [1:0] stp,
                                             input logic [7:0] d,
                                             input logic       rs,
                                             input logic       bl);
        logic [3:0] nib;
        nib = stp[1] ? d[3:0] : d[7:4];
        return {nib, bl, ~stp[0], 1'b0, rs};
    endfunction

    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
            state    <= S_IDLE;
            step     <= '0;
            gap_cnt  <= '0;
            err_flag <= 1'b0;
            i2c_data <= '0;
            data_q   <= '0;
            rs_q     <= 1'b0;
            bl_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ena_write) begin
                        data_q   <= data;
                        rs_q     <= cmd_data;
                        bl_q     <= backlight;
                        step     <= '0;
                        i2c_data <= port_byte(2'd0, data, cmd_data, backlight);
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i2c_done) begin
                        if (i2c_ack_err) begin
                            err_flag <= 1'b1;
                            state    <= S_FIN;
                        end else begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    // Counter runs 0..GAP_CYCLES, so GAP spans GAP_CYCLES+1
                    // cycles (one cycle when GAP_CYCLES is 0).
                    if (gap_cnt == GAP_LAST) begin
                        if (step == 2'd3) begin
                            state <= S_FIN;
                        end else begin
                            step     <= step + 2'd1;
                            i2c_data <= port_byte(step + 2'd1, data_q, rs_q, bl_q);
                            state    <= S_SEND;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    err_flag <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Pulses decode straight from the registered state, so they are glitch
    // free and need no extra clear logic.
    assign i2c_start  = (state == S_SEND);
    assign busy       = (state != S_IDLE);
    assign done_write = (state == S_FIN);
    assign err        = (state == S_FIN) && err_flag;
    assign i2c_addr   = SLAVE_ADDR;

endmodule

// File: tb/tb_i2c_lcd_byte_sender.sv
module tb_i2c_lcd_byte_sender;

    localparam int MLAT = 20;   // master latency: i2c_done this many cycles after start
    localparam int GAP  = 50;
    localparam int S2S  = MLAT + GAP + 2;

    logic       clk_1MHz = 1'b0;
    logic       rst;
    logic       ena_write;
    logic [7:0] data;
    logic       cmd_data;
    logic       backlight;
    logic       done_write;
    logic       busy;
    logic       err;
    logic       i2c_start;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_data;
    logic       i2c_done;
    logic       i2c_ack_err;

    always #500 clk_1MHz = ~clk_1MHz;

    i2c_lcd_byte_sender #(.SLAVE_ADDR(7'h27), .GAP_CYCLES(GAP)) dut (
        .clk_1MHz   (clk_1MHz),
        .rst        (rst),
        .ena_write  (ena_write),
        .data       (data),
        .cmd_data   (cmd_data),
        .backlight  (backlight),
        .done_write (done_write),
        .busy       (busy),
        .err        (err),
        .i2c_start  (i2c_start),
        .i2c_addr   (i2c_addr),
        .i2c_data   (i2c_data),
        .i2c_done   (i2c_done),
        .i2c_ack_err(i2c_ack_err)
    );

    int cyc = 0;
    always @(posedge clk_1MHz) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         start_cyc[$];

    int   total_bytes = 0;
    int   nack_at     = -1;
    int   m_cnt       = 0;
    int   stray_req   = 0;
    int   stray_ack   = 0;

    // I2C byte master model: captures each start, answers MLAT cycles later.
    initial begin
        i2c_done    = 1'b0;
        i2c_ack_err = 1'b0;
        forever begin
            @(posedge clk_1MHz);
            #1;
            i2c_done    = 1'b0;
            i2c_ack_err = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    i2c_done    = 1'b1;
                    i2c_ack_err = (total_bytes == nack_at);
                    total_bytes++;
                end
            end else if (stray_req != stray_ack) begin
                i2c_done    = 1'b1;
                i2c_ack_err = 1'b1;
                stray_ack   = stray_req;
            end
            if (i2c_start === 1'b1) begin
                obs_q.push_back(i2c_data);
                start_cyc.push_back(cyc);
                m_cnt = MLAT;
            end
        end
    end

    function automatic logic [7:0] lcd_byte(input logic [7:0] d, input logic rs,
                                            input logic bl, input int stp);
        logic [7:0] b;
        b = (stp < 2) ? (d & 8'hF0) : ((d & 8'h0F) * 8'd16);
        if (bl)          b = b | 8'h08;
        if (stp % 2 == 0) b = b | 8'h04;
        if (rs)          b = b | 8'h01;
        return b;
    endfunction

    task automatic send(input logic [7:0] d, input logic cd, input logic bl,
                        input int nexp, output int acc_cyc);
        @(posedge clk_1MHz);
        #1;
        data      = d;
        cmd_data  = cd;
        backlight = bl;
        ena_write = 1'b1;
        acc_cyc   = cyc;
        for (int s = 0; s < nexp; s++) exp_q.push_back(lcd_byte(d, cd, bl, s));
        @(posedge clk_1MHz);
        #1;
        ena_write = 1'b0;
    endtask

    task automatic poke_ena(input logic [7:0] d);
        ena_write = 1'b1;
        data      = d;
        cmd_data  = ~cmd_data;
        backlight = ~backlight;
        @(posedge clk_1MHz);
        #1;
        ena_write = 1'b0;
    endtask

    // Waits (bounded) for done_write; counts busy drops on the way.
    task automatic wait_done(input int budget, input logic poke_fin, output int dcyc,
                             output logic derr, output logic ok, output int drops);
        ok = 1'b0; derr = 1'b0; dcyc = -1; drops = 0;
        for (int i = 0; i < budget; i++) begin
            if (busy !== 1'b1) drops++;
            if (done_write === 1'b1) begin
                ok   = 1'b1;
                derr = err;
                dcyc = cyc;
                break;
            end
            @(posedge clk_1MHz);
            #1;
        end
        if (ok && poke_fin) begin
            ena_write = 1'b1;
            data      = 8'hEE;
            @(posedge clk_1MHz);
            #1;
            ena_write = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ena_write = 1'b0; data = '0; cmd_data = 1'b0; backlight = 1'b0;
        repeat (3) @(posedge clk_1MHz);
        #1;
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0)       begin n_mis++; $display("FAIL reset_busy actual=%b required=0", busy); end
        n_cmp++; if (done_write !== 1'b0) begin n_mis++; $display("FAIL reset_done actual=%b required=0", done_write); end
        n_cmp++; if (err !== 1'b0)        begin n_mis++; $display("FAIL reset_err actual=%b required=0", err); end
        n_cmp++; if (i2c_start !== 1'b0)  begin n_mis++; $display("FAIL reset_start actual=%b required=0", i2c_start); end
        n_cmp++; if (i2c_data !== 8'h00)  begin n_mis++; $display("FAIL reset_data actual=%h required=00", i2c_data); end
        n_cmp++; if (i2c_addr !== 7'h27)  begin n_mis++; $display("FAIL reset_addr actual=%h required=27", i2c_addr); end
    endtask

    task automatic test_char();
        int acc, dcyc, drops; logic derr, ok; logic [7:0] e, o;
        start_cyc.delete();
        exp_q.push_back(8'h4D); exp_q.push_back(8'h49);
        exp_q.push_back(8'h1D); exp_q.push_back(8'h19);
        send(8'h41, 1'b1, 1'b1, 0, acc);
        wait_done(600, 1'b0, dcyc, derr, ok, drops);
        n_cmp++; if (!ok)           begin n_mis++; $display("FAIL char_done timeout actual=none required=pulse"); end
        n_cmp++; if (derr !== 1'b0) begin n_mis++; $display("FAIL char_err actual=%b required=0", derr); end
        n_cmp++; if (drops != 0)    begin n_mis++; $display("FAIL char_busy drops actual=%0d required=0", drops); end
        n_cmp++;
        if (start_cyc.size() != 4) begin
            n_mis++; $display("FAIL char_starts actual=%0d required=4", start_cyc.size());
        end else begin
            n_cmp++; if (start_cyc[0] - acc != 1) begin n_mis++; $display("FAIL char_latency actual=%0d required=1", start_cyc[0] - acc); end
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (start_cyc[i+1] - start_cyc[i] != S2S) begin
                    n_mis++; $display("FAIL char_s2s[%0d] actual=%0d required=%0d", i, start_cyc[i+1] - start_cyc[i], S2S);
                end
            end
            n_cmp++; if (dcyc - start_cyc[3] != S2S) begin n_mis++; $display("FAIL char_fin_time actual=%0d required=%0d", dcyc - start_cyc[3], S2S); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_mis++; $display("FAIL char_byte actual=none required=%h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_mis++; $display("FAIL char_byte actual=%h required=%h", o, e); end end
        end
    endtask

    task automatic test_cmd();
        int acc, dcyc, drops; logic derr, ok; logic [7:0] e, o;
        exp_q.push_back(8'h2C); exp_q.push_back(8'h28);
        exp_q.push_back(8'h8C); exp_q.push_back(8'h88);
        send(8'h28, 1'b0, 1'b1, 0, acc);
        wait_done(600, 1'b0, dcyc, derr, ok, drops);
        n_cmp++; if (!ok || derr !== 1'b0) begin n_mis++; $display("FAIL cmd1_done actual=ok%b err%b required=ok1 err0", ok, derr); end
        // Back-to-back: next request lands in the first IDLE cycle after FIN.
        exp_q.push_back(8'h04); exp_q.push_back(8'h00);
        exp_q.push_back(8'h14); exp_q.push_back(8'h10);
        send(8'h01, 1'b0, 1'b0, 0, acc);
        wait_done(600, 1'b0, dcyc, derr, ok, drops);
        n_cmp++; if (!ok || derr !== 1'b0) begin n_mis++; $display("FAIL cmd2_done actual=ok%b err%b required=ok1 err0", ok, derr); end
        exp_q.push_back(lcd_byte(8'hC3, 1'b1, 1'b0, 0)); exp_q.push_back(lcd_byte(8'hC3, 1'b1, 1'b0, 1));
        exp_q.push_back(lcd_byte(8'hC3, 1'b1, 1'b0, 2)); exp_q.push_back(lcd_byte(8'hC3, 1'b1, 1'b0, 3));
        send(8'hC3, 1'b1, 1'b0, 0, acc);
        wait_done(600, 1'b0, dcyc, derr, ok, drops);
        n_cmp++; if (!ok) begin n_mis++; $display("FAIL cmd3_done actual=none required=pulse"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_mis++; $display("FAIL cmd_byte actual=none required=%h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_mis++; $display("FAIL cmd_byte actual=%h required=%h", o, e); end end
        end
    endtask

    task automatic test_nack();
        int acc, dcyc, drops; logic derr, ok; logic [7:0] e, o;
        start_cyc.delete();
        nack_at = total_bytes + 1;
        send(8'h55, 1'b1, 1'b1, 2, acc);
        wait_done(600, 1'b0, dcyc, derr, ok, drops);
        nack_at = -1;
        n_cmp++; if (!ok)           begin n_mis++; $display("FAIL nack_done actual=none required=pulse"); end
        n_cmp++; if (derr !== 1'b1) begin n_mis++; $display("FAIL nack_err actual=%b required=1", derr); end
        repeat (100) @(posedge clk_1MHz);
        #1;
        n_cmp++;
        if (start_cyc.size() != 2) begin
            n_mis++; $display("FAIL nack_starts actual=%0d required=2", start_cyc.size());
        end else begin
            n_cmp++; if (dcyc - start_cyc[1] != MLAT + 1) begin n_mis++; $display("FAIL nack_fin_time actual=%0d required=%0d", dcyc - start_cyc[1], MLAT + 1); end
        end
        send(8'h9A, 1'b1, 1'b1, 4, acc);
        wait_done(600, 1'b0, dcyc, derr, ok, drops);
        n_cmp++; if (!ok || derr !== 1'b0) begin n_mis++; $display("FAIL nack_next actual=ok%b err%b required=ok1 err0", ok, derr); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_mis++; $display("FAIL nack_byte actual=none required=%h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_mis++; $display("FAIL nack_byte actual=%h required=%h", o, e); end end
        end
    endtask

    task automatic test_ignore();
        int acc, dcyc, drops, nobs; logic derr, ok; logic [7:0] e, o;
        // Stray done while idle must not start anything.
        stray_req++;
        repeat (5) @(posedge clk_1MHz);
        #1;
        n_cmp++; if (busy !== 1'b0 || obs_q.size() != 0) begin n_mis++; $display("FAIL idle_stray actual=busy%b n%0d required=busy0 n0", busy, obs_q.size()); end
        send(8'hA5, 1'b1, 1'b0, 4, acc);
        for (int i = 0; i < 50 && obs_q.size() == 0; i++) begin @(posedge clk_1MHz); #1; end
        repeat (5) @(posedge clk_1MHz);
        #1;
        poke_ena(8'hFF);                 // during WAIT
        repeat (25) @(posedge clk_1MHz);
        #1;
        poke_ena(8'h00);                 // during GAP
        stray_req++;                     // stray NACK-flavoured done during GAP
        wait_done(600, 1'b1, dcyc, derr, ok, drops);  // plus a poke in FIN
        n_cmp++; if (!ok || derr !== 1'b0) begin n_mis++; $display("FAIL ign_done actual=ok%b err%b required=ok1 err0", ok, derr); end
        n_cmp++; if (drops != 0)           begin n_mis++; $display("FAIL ign_busy drops actual=%0d required=0", drops); end
        nobs = obs_q.size();
        repeat (10) @(posedge clk_1MHz);
        #1;
        n_cmp++; if (busy !== 1'b0 || obs_q.size() != nobs) begin n_mis++; $display("FAIL ign_fin_poke actual=busy%b n%0d required=busy0 n%0d", busy, obs_q.size(), nobs); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_mis++; $display("FAIL ign_byte actual=none required=%h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_mis++; $display("FAIL ign_byte actual=%h required=%h", o, e); end end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_mis++; $display("FAIL ign_extra actual=%0d required=0", obs_q.size()); end
    endtask

    task automatic test_reset_mid();
        int acc, dcyc, drops, ndone; logic derr, ok; logic [7:0] e, o;
        send(8'h3C, 1'b0, 1'b1, 3, acc);
        for (int i = 0; i < 400 && obs_q.size() < 3; i++) begin @(posedge clk_1MHz); #1; end
        repeat (30) @(posedge clk_1MHz);  // done at +20, now inside the step-2 gap
        #1;
        rst = 1'b1;
        @(posedge clk_1MHz);
        #1;
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done_write !== 1'b0 || err !== 1'b0 || i2c_start !== 1'b0 || i2c_data !== 8'h00) begin
            n_mis++; $display("FAIL rstmid_outs actual=b%b d%b e%b s%b %h required=b0 d0 e0 s0 00", busy, done_write, err, i2c_start, i2c_data);
        end
        ndone = 0;
        for (int i = 0; i < 150; i++) begin
            if (done_write === 1'b1) ndone++;
            @(posedge clk_1MHz);
            #1;
        end
        n_cmp++; if (ndone != 0) begin n_mis++; $display("FAIL rstmid_nodone actual=%0d required=0", ndone); end
        send(8'h7E, 1'b1, 1'b1, 4, acc);
        wait_done(600, 1'b0, dcyc, derr, ok, drops);
        n_cmp++; if (!ok || derr !== 1'b0) begin n_mis++; $display("FAIL rstmid_next actual=ok%b err%b required=ok1 err0", ok, derr); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_mis++; $display("FAIL rstmid_byte actual=none required=%h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_mis++; $display("FAIL rstmid_byte actual=%h required=%h", o, e); end end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_mis++; $display("FAIL rstmid_extra actual=%0d required=0", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_char();
        test_cmd();
        test_nack();
        test_ignore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/i2c_lcd_byte_sender.md
I2C_LCD_BYTE_SENDER -- requirements
Module: i2c_lcd_byte_sender

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h27: PCF8574 backpack address, driven on i2c_addr.
REQ-002 Parameter GAP_CYCLES, default 50: clk_1MHz cycles of idle after each completed I2C byte (50 us).
REQ-003 clk_1MHz  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ena_write  in  1  one-cycle request to send data to the LCD.
REQ-006 data  in  8  byte to send (command or character).
REQ-007 cmd_data  in  1  0 = command (RS=0), 1 = character data (RS=1).
REQ-008 backlight  in  1  backlight bit value for all four bytes of a transfer.
REQ-009 done_write  out  1  one-cycle pulse: transfer finished or aborted.
REQ-010 busy  out  1  high from acceptance until the done_write cycle inclusive.
REQ-011 err  out  1  one-cycle pulse with done_write when a transfer is aborted on NACK.
REQ-012 i2c_start  out  1  one-cycle request to the I2C byte master.
REQ-013 i2c_addr  out  7  constant SLAVE_ADDR.
REQ-014 i2c_data  out  8  PCF8574 port byte; stable from i2c_start until i2c_done.
REQ-015 i2c_done  in  1  one-cycle pulse: master finished the current byte.
REQ-016 i2c_ack_err  in  1  qualified by i2c_done; 1 = slave NACK.

Function
REQ-017 The block shall implement states IDLE, SEND, WAIT, GAP, FIN.
REQ-018 In IDLE, ena_write=1 shall latch data, cmd_data, backlight, clear the step counter (0..3), and go to SEND next cycle.
REQ-019 ena_write while busy=1 shall be ignored; latched values shall not change.
REQ-020 Port byte mapping: bit0=RS, bit1=RW=0, bit2=EN, bit3=BL, bits7:4=nibble.
REQ-021 Step 0: high nibble, EN=1; step 1: high nibble, EN=0; step 2: low nibble, EN=1; step 3: low nibble, EN=0.
REQ-022 SEND shall drive i2c_data for the current step, pulse i2c_start for exactly that one cycle, and go to WAIT.
REQ-023 WAIT shall hold until i2c_done=1; i2c_done in any other state shall be ignored.
REQ-024 i2c_done=1 with i2c_ack_err=0: clear the gap counter and go to GAP.
REQ-025 i2c_done=1 with i2c_ack_err=1: skip remaining steps and go to FIN with the error flag set.
REQ-026 GAP shall count GAP_CYCLES cycles, then go to SEND with step+1 if step<3, else go to FIN.
REQ-027 The gap shall apply after every byte, including step 3.
REQ-028 FIN shall pulse done_write for one cycle, pulse err if the error flag is set, clear the flag, and return to IDLE.
REQ-029 ena_write sampled in the FIN cycle shall be ignored; a new transfer may be accepted in the first IDLE cycle after it.
REQ-030 With GAP_CYCLES=0, GAP shall last one cycle.
REQ-031 Latency: i2c_start shall assert 1 cycle after ena_write is accepted.
REQ-032 Latency: between consecutive i2c_start pulses there shall be (master latency + GAP_CYCLES + 2) cycles.

Reset
REQ-033 rst=1 at a clock edge shall force IDLE, step=0, counters=0, error flag=0, done_write=0, busy=0, err=0, i2c_start=0, and i2c_data=8'h00.
REQ-034 rst asserted mid-transfer shall abort it without a done_write pulse.
REQ-035 The first ena_write after rst deasserts shall be accepted normally.

Verification
REQ-036 Char: data=0x41, cmd_data=1, backlight=1 -> i2c_data 0x4D, 0x49, 0x1D, 0x19, then one done_write, err=0.
REQ-037 Command: data=0x28, cmd_data=0, backlight=1 -> 0x2C, 0x28, 0x8C, 0x88; backlight=0 with data=0x01 -> 0x04, 0x00, 0x14, 0x10.
REQ-038 Timing: master returns i2c_done 20 cycles after each start, GAP_CYCLES=50 -> start-to-start = 72 cycles; done_write 1 cycle after the last gap ends; busy never drops mid-transfer.
REQ-039 NACK: i2c_ack_err=1 on the byte 2 done -> no third i2c_start; done_write and err pulse together 1 cycle later; the next ena_write then sends 4 bytes.
REQ-040 Robustness: ena_write pulsed during WAIT/GAP/FIN -> ignored and output bytes unchanged; stray i2c_done in IDLE/GAP -> no effect.
REQ-041 Reset mid-operation: rst pulsed during the step 2 GAP -> all outputs 0 next cycle, no done_write; a following transfer completes with correct bytes.
